// File: rtl/redundancy_pair_scheduler.sv
// rtl/redundancy_pair_scheduler.sv - sequences redundant weight-index pairs through the distance calculator
//
// Latches the layer shape (OW, FW, S) on an accepted start, takes (idx1, idx2)
// pairs on a valid/ready stream and holds each one in a stage register that
// drives the external combinational distance calculator. Valid results are
// presented on an output valid/ready stream; invalid ones are dropped.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, cfg_ow/fw/st           layer start pulse and shape configuration
//   busy, done, cfg_err           layer status (done/cfg_err are one-cycle pulses)
//   pair_valid/ready/idx1/idx2/last  input pair stream
//   calc_idx1/idx2/ow/fw/st       operands to the distance calculator
//   calc_valid, calc_dr           calculator result
//   out_valid/ready/idx1/idx2/dr  output distance stream
//   pair_cnt, drop_cnt            per-layer accepted / dropped pair counters
//
// Optional feature macro: RC_DROP_CNT_EN
//   defined   : drop_cnt counts dropped pairs
//   undefined : drop counter omitted, drop_cnt tied to 0

module redundancy_pair_scheduler #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_ow,
    input  logic [WORD_WIDTH-1:0] cfg_fw,
    input  logic [WORD_WIDTH-1:0] cfg_st,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    input  logic                  pair_valid,
    output logic                  pair_ready,
    input  logic [WORD_WIDTH-1:0] pair_idx1,
    input  logic [WORD_WIDTH-1:0] pair_idx2,
    input  logic                  pair_last,
    output logic [WORD_WIDTH-1:0] calc_idx1,
    output logic [WORD_WIDTH-1:0] calc_idx2,
    output logic [WORD_WIDTH-1:0] calc_ow,
    output logic [WORD_WIDTH-1:0] calc_fw,
    output logic [WORD_WIDTH-1:0] calc_st,
    input  logic                  calc_valid,
    input  logic [DIST_WIDTH-1:0] calc_dr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_idx1,
    output logic [WORD_WIDTH-1:0] out_idx2,
    output logic [DIST_WIDTH-1:0] out_dr,
    output logic [CNT_WIDTH-1:0]  pair_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]            state;
    logic [WORD_WIDTH-1:0] cfg_ow_q, cfg_fw_q, cfg_st_q;
    logic [WORD_WIDTH-1:0] s1_idx1, s1_idx2;
    logic                  s1_last;
    logic                  s1_v;

    logic cfg_ok, start_ok, advance, accept, load_out, layer_empty;

    assign cfg_ok      = (cfg_fw != '0) && (cfg_st != '0) && (cfg_ow >= cfg_fw);
    assign start_ok    = (state == ST_IDLE) && start && cfg_ok;
    assign advance     = s1_v && (!out_valid || out_ready);
    assign pair_ready  = (state == ST_RUN) && (!s1_v || advance);
    assign accept      = pair_valid && pair_ready;
    // Only a strictly ordered pair with a valid calculator result is kept;
    // idx2 <= idx1 is rejected even if the calculator claims validity.
    assign load_out    = advance && calc_valid && (s1_idx2 > s1_idx1);
    assign layer_empty = !s1_v && !out_valid;
    assign busy        = (state != ST_IDLE);

    // Calculator operands come only from registers, never from pair_*.
    assign calc_idx1 = s1_idx1;
    assign calc_idx2 = s1_idx2;
    assign calc_ow   = cfg_ow_q;
    assign calc_fw   = cfg_fw_q;
    assign calc_st   = cfg_st_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cfg_ow_q <= '0;
            cfg_fw_q <= '0;
            cfg_st_q <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= (state == ST_FLUSH) && layer_empty;
            cfg_err <= (state == ST_IDLE) && start && !cfg_ok;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        cfg_ow_q <= cfg_ow;
                        cfg_fw_q <= cfg_fw;
                        cfg_st_q <= cfg_st;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && pair_last) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (layer_empty) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_idx1 <= '0;
            s1_idx2 <= '0;
            s1_last <= 1'b0;
            s1_v    <= 1'b0;
        end else if (accept) begin
            s1_idx1 <= pair_idx1;
            s1_idx2 <= pair_idx2;
            s1_last <= pair_last;
            s1_v    <= 1'b1;
        end else if (advance) begin
            s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_idx1  <= '0;
            out_idx2  <= '0;
            out_dr    <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_idx1  <= s1_idx1;
            out_idx2  <= s1_idx2;
            out_dr    <= calc_dr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_cnt <= '0;
        end else if (start_ok) begin
            pair_cnt <= '0;
        end else if (accept && (pair_cnt != CNT_MAX)) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

`ifdef RC_DROP_CNT_EN
    logic drop;
    assign drop = advance && !load_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (start_ok) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

    // s1_last is kept with the pair for observability; layer end is tracked
    // by the FSM at acceptance time.
    logic unused_s1_last;
    assign unused_s1_last = s1_last;

endmodule

// File: doc/redundancy_pair_scheduler.md
Name: redundancy_pair_scheduler

Overview:
- Sequences redundant weight-index pairs through the combinational distance calculator.
- Latches layer shape config (OW, FW, S) on start and accepts a stream of (idx1, idx2) pairs.
- Drives the calculator from a registered stage, filters out invalid results, and emits only valid output-pixel distances on a valid/ready stream.
- Sits between the redundancy-detection front end and the output-reuse buffer controller.

Parameters:
WORD_WIDTH, 8, width of indices and shape fields
DIST_WIDTH, 7, width of distance result
CNT_WIDTH, 16, width of pair/drop counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch config and begin a layer
cfg_ow  in  WORD_WIDTH  output width OW
cfg_fw  in  WORD_WIDTH  filter width FW
cfg_st  in  WORD_WIDTH  stride S
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of layer
cfg_err  out  1  one-cycle pulse when start rejected
pair_valid  in  1  input pair present
pair_ready  out  1  scheduler accepts pair
pair_idx1  in  WORD_WIDTH  smaller index
pair_idx2  in  WORD_WIDTH  larger index
pair_last  in  1  final pair of layer
calc_idx1, calc_idx2, calc_ow, calc_fw, calc_st  out  WORD_WIDTH each  operands to distance calculator
calc_valid  in  1  calculator result valid
calc_dr  in  DIST_WIDTH  calculator distance
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_idx1, out_idx2  out  WORD_WIDTH  pair producing result
out_dr  out  DIST_WIDTH  distance of redundant output pixel
pair_cnt  out  CNT_WIDTH  pairs accepted this layer
drop_cnt  out  CNT_WIDTH  pairs dropped this layer

Behaviour:
- Reset: state=IDLE. All outputs, stage registers and counters are 0; config registers are 0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - start with cfg_fw==0, cfg_st==0 or cfg_ow<cfg_fw pulses cfg_err for one cycle; state stays IDLE.
  - Otherwise latch config, clear pair_cnt/drop_cnt, and go to RUN. busy=1 from the next cycle.
- start in RUN or FLUSH is ignored.
- Stage 1 (S1) register holds idx1, idx2, last and s1_v. calc_* are driven directly from the S1 and config registers, with no combinational path from pair_*.
- advance = s1_v & (~out_valid | out_ready).
- pair_ready = (state==RUN) & (~s1_v | advance).
- Acceptance: on pair_valid & pair_ready, S1 loads the pair, pair_cnt increments, and s1_v is set. If pair_last, state goes to FLUSH in the same edge and pair_ready drops.
- On advance:
  - If calc_valid & (idx2 > idx1): the output register loads idx1, idx2 and calc_dr, and out_valid is set.
  - Otherwise the pair is dropped and drop_cnt increments. idx2<=idx1 always drops, regardless of calc_valid.
- s1_v clears on advance unless a new pair is accepted in the same cycle (full throughput: 1 pair/cycle with out_ready=1).
- out_valid clears on out_ready when there is no new load. The output register holds stable while out_valid & ~out_ready.
- Latency: pair accepted at edge N gives out_valid at edge N+1.
- FLUSH: when s1_v==0 and out_valid==0, pulse done for one cycle, set busy=0, and go to IDLE.
- A last pair that is dropped still completes the layer normally.
- Counters saturate at all-ones and do not wrap.
- Asynchronous reset mid-layer discards all in-flight pairs immediately. No done pulse is produced.

Optional Feature:
RC_DROP_CNT_EN:
- Defined: drop_cnt behaves as above.
- Undefined: the drop counter logic is omitted and drop_cnt is tied to 0. pair_cnt is unaffected.

Test Plan:
- ow=6, fw=3, st=1; pairs (0,4), then (1,2) with last -> out (0,4,dr=7), then (1,2,dr=1); done 1 cycle after the 2nd output handshake; pair_cnt=2, drop_cnt=0.
- ow=6, fw=3, st=2, bench calculator model; pair (0,4) last (dr_nst=7, odd) -> calc_valid=0, no out_valid, drop_cnt=1, done pulses.
- start with fw=0 -> cfg_err pulse, busy stays 0, pair_ready stays 0; then a valid start is accepted normally.
- 4 back-to-back pairs with out_ready=0 for 3 cycles -> pair_ready low after S1 fills, out_* held stable, no loss or duplication, 4 outputs in order once released.
- pair (5,5) with calc_valid forced 1 -> dropped, drop_cnt=1; with RC_DROP_CNT_EN undefined, drop_cnt=0.
- reset_n low mid-RUN with out_valid=1 -> out_valid, busy and counters go to 0 asynchronously; after release state is IDLE and pair_ready=0.
